uart_tx_fifo_drain: RTL and testbench

UART transmitter that drains the byte FIFO toward the serial line. It pulls one byte at a time through the FIFO read port. The port contract is: read enable, data plus a one-cycle-late valid, and an empty flag. Each byte is serialised as 8N1/8N2, LSB first. It sits between the output FIFO of the case-conversion path and the TX pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_fifo_drain.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam logic UART_IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Produces a one-cycle tick on the last clock of every bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pulls bytes from a FIFO read port and sends them
// as 8N1/8N2 frames, LSB first.
import uart_pkg::*;

module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [DATA_BITS-1:0] i_fifo_rd_data,
    input  logic                 i_fifo_rd_valid,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            next_state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 tick;
    logic                 baud_clear;

    // Restart the bit period exactly when the start bit goes out.
    assign baud_clear = (state == WAIT) && i_fifo_rd_valid;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(baud_clear),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_enable && !i_fifo_empty) next_state = REQ;
            REQ:     next_state = WAIT;
            WAIT:    next_state = i_fifo_rd_valid ? START : IDLE;
            START:   if (tick) next_state = DATA;
            DATA:    if (tick && (bit_idx == LAST_DATA)) next_state = STOP;
            STOP:    if (tick && (bit_idx == LAST_STOP)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // o_tx is registered so it moves on the same edge as the state change;
    // the shifter pre-shifts so shift_reg[0] always holds the next bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tx      <= UART_IDLE_LEVEL;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (i_fifo_rd_valid) begin
                        shift_reg <= i_fifo_rd_data;
                        o_tx      <= 1'b0;
                        bit_idx   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        o_tx      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA) begin
                            o_tx    <= UART_IDLE_LEVEL;
                            bit_idx <= '0;
                        end else begin
                            o_tx      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        bit_idx <= (bit_idx == LAST_STOP) ? '0 : bit_idx + 1'b1;
                    end
                end
                default: o_tx <= UART_IDLE_LEVEL;
            endcase
        end
    end

    assign o_fifo_rd_en = (state == REQ);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == STOP) && tick && (bit_idx == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: FIFO model, serial receiver
// monitor and an expected-byte scoreboard; a second instance uses two stop bits.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst1 = 1'b1;
    logic       en = 1'b0;
    logic       withhold = 1'b0;

    logic       fifo_empty = 1'b1;
    logic       rd_en;
    logic [7:0] rd_data = 8'h00;
    logic       rd_valid = 1'b0;
    logic       tx, busy, done;

    logic       fifo_empty1 = 1'b1;
    logic       rd_en1;
    logic [7:0] rd_data1 = 8'h00;
    logic       rd_valid1 = 1'b0;
    logic       tx1, busy1, done1;

    logic [7:0] fifo_q[$];
    logic [7:0] fifo1_q[$];
    logic [7:0] exp_q[$];

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         rd_count = 0;
    int         frames_done = 0;
    int         rx_cyc = 0;
    int         gap_cnt = 0;
    logic       rx_active = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] exp_byte;
    logic       expect_gap = 1'b0;

    int         high_run1 = 0;
    int         gap1 = 0;
    int         done_cnt1 = 0;
    logic       gap1_taken = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (en),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (rd_en),
        .i_fifo_rd_data (rd_data),
        .i_fifo_rd_valid(rd_valid),
        .o_tx           (tx),
        .o_busy         (busy),
        .o_done         (done)
    );

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut_stop2 (
        .i_clk          (clk),
        .i_rst          (rst1),
        .i_enable       (1'b1),
        .i_fifo_empty   (fifo_empty1),
        .o_fifo_rd_en   (rd_en1),
        .i_fifo_rd_data (rd_data1),
        .i_fifo_rd_valid(rd_valid1),
        .o_tx           (tx1),
        .o_busy         (busy1),
        .o_done         (done1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            waitCycle();
            n++;
        end
        checkOutput("frame_timeout", frames_done >= target, 1);
    endtask

    // FIFO with one-cycle read latency; withhold suppresses valid for a read.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_count++;
            if (!withhold && fifo_q.size() > 0) begin
                rd_data  <= fifo_q.pop_front();
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_en1 && fifo1_q.size() > 0) begin
            rd_data1  <= fifo1_q.pop_front();
            rd_valid1 <= 1'b1;
        end else begin
            rd_valid1 <= 1'b0;
        end
        fifo_empty1 <= (fifo1_q.size() == 0);
    end

    // Serial receiver: frame cycle 0 is the first low cycle of the start bit.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_active && exp_q.size() > 0) exp_byte = exp_q.pop_front();
            rx_active = 1'b0;
            rx_cyc    = 0;
            gap_cnt   = 0;
        end else if (!rx_active) begin
            if (done) checkOutput("done_spurious", done, 0);
            if (tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cyc    = 0;
                rx_byte   = 8'h00;
                if (expect_gap) checkOutput("gap_high", gap_cnt + CPB, CPB + 3);
            end else begin
                gap_cnt++;
            end
        end else begin
            rx_cyc++;
            if (rx_cyc == 2) checkOutput("start_bit", tx, 0);
            if (rx_cyc >= 5 && rx_cyc <= 33 && (rx_cyc % 4) == 1) rx_byte[(rx_cyc - 5) / 4] = tx;
            if (rx_cyc == 37) checkOutput("stop_bit", tx, 1);
            if (rx_cyc == 38) checkOutput("done_early", done, 0);
            if (rx_cyc == 39) begin
                checkOutput("done_pulse", done, 1);
                if (exp_q.size() == 0) begin
                    checkOutput("sb_underflow", exp_q.size(), 1);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("rx_byte", rx_byte, exp_byte);
                end
                rx_active = 1'b0;
                gap_cnt   = 0;
                frames_done++;
            end
        end
    end

    // Two-stop-bit instance: measure the high run ahead of its second frame.
    always @(negedge clk) begin
        if (!rst1) begin
            if (done1) done_cnt1++;
            if (tx1) begin
                high_run1++;
            end else begin
                if (done_cnt1 == 1 && !gap1_taken) begin
                    gap1       = high_run1;
                    gap1_taken = 1'b1;
                end
                high_run1 = 0;
            end
        end
    end

    initial begin
        int base;
        int rd0;
        int n;

        fifo1_q.push_back(8'h61);
        fifo1_q.push_back(8'h7A);
        applyStimulus(8'h41);

        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("rst_tx", tx, 1);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_rd_en", rd_en, 0);
        end
        rst  = 1'b0;
        rst1 = 1'b0;
        waitCycle();
        checkOutput("post_rst_tx", tx, 1);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_rd_en", rd_en, 0);

        $display("[TB] single byte 0x41");
        en = 1'b1;
        waitCycle();
        checkOutput("enable_req", rd_en, 1);
        checkOutput("enable_busy", busy, 1);
        waitCycle();
        checkOutput("req_one_cycle", rd_en, 0);
        waitFrames(1, 100);
        checkOutput("single_rd_cnt", rd_count, 1);

        $display("[TB] back-to-back 0x61 0x7A");
        base = frames_done;
        rd0  = rd_count;
        applyStimulus(8'h61);
        applyStimulus(8'h7A);
        waitCycle();
        checkOutput("empty_fell", fifo_empty, 0);
        checkOutput("rd_en_not_yet", rd_en, 0);
        waitCycle();
        checkOutput("rd_en_after_empty", rd_en, 1);
        waitFrames(base + 1, 100);
        expect_gap = 1'b1;
        waitFrames(base + 2, 100);
        expect_gap = 1'b0;
        checkOutput("b2b_rd_cnt", rd_count - rd0, 2);

        $display("[TB] empty FIFO idle");
        rd0 = rd_count;
        for (int i = 0; i < 20; i++) waitCycle();
        checkOutput("empty_rd_cnt", rd_count - rd0, 0);
        checkOutput("empty_tx", tx, 1);
        checkOutput("empty_busy", busy, 0);

        $display("[TB] withheld read valid");
        base = frames_done;
        rd0  = rd_count;
        withhold = 1'b1;
        applyStimulus(8'h33);
        n = 0;
        while (!rd_en && n < 20) begin
            waitCycle();
            n++;
        end
        checkOutput("withhold_req", rd_en, 1);
        waitCycle();
        checkOutput("withhold_valid", rd_valid, 0);
        checkOutput("withhold_wait_busy", busy, 1);
        checkOutput("withhold_wait_tx", tx, 1);
        withhold = 1'b0;
        waitCycle();
        checkOutput("withhold_idle", busy, 0);
        checkOutput("withhold_tx", tx, 1);
        checkOutput("withhold_done", done, 0);
        waitFrames(base + 1, 100);
        checkOutput("withhold_rd_cnt", rd_count - rd0, 2);

        $display("[TB] reset during data bit 3");
        base = frames_done;
        rd0  = rd_count;
        applyStimulus(8'h55);
        applyStimulus(8'h2C);
        n = 0;
        while (!(rx_active && rx_cyc == 17) && n < 60) begin
            waitCycle();
            n++;
        end
        checkOutput("reach_bit3", rx_cyc, 17);
        rst = 1'b1;
        waitCycle();
        checkOutput("abort_tx", tx, 1);
        checkOutput("abort_busy", busy, 0);
        rst = 1'b0;
        waitFrames(base + 1, 120);
        checkOutput("abort_rd_cnt", rd_count - rd0, 2);

        $display("[TB] enable dropped mid-frame");
        base = frames_done;
        rd0  = rd_count;
        applyStimulus(8'h5A);
        applyStimulus(8'hA5);
        n = 0;
        while (!rx_active && n < 20) begin
            waitCycle();
            n++;
        end
        en = 1'b0;
        waitFrames(base + 1, 100);
        for (int i = 0; i < 10; i++) waitCycle();
        checkOutput("disabled_rd_cnt", rd_count - rd0, 1);
        checkOutput("disabled_busy", busy, 0);
        checkOutput("disabled_rd_en", rd_en, 0);
        en = 1'b1;
        waitCycle();
        checkOutput("reenable_req", rd_en, 1);
        waitFrames(base + 2, 100);

        checkOutput("sb_drained", exp_q.size(), 0);
        checkOutput("stop2_done_cnt", done_cnt1, 2);
        checkOutput("stop2_gap", gap1, 2 * CPB + 3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
